// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared core package: divider FSM states and register one-hot decode.
// Provides REG_WIDTH/DATA_WIDTH defaults when the core has not set them.
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package issue_hazard_ctrl_pkg;

    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // x0 is hardwired zero, so its bit is always masked off.
    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic [`REG_WIDTH-1:0] addr
    );
        logic [NUM_REGS-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        oh[0]    = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/issue_hazard_ctrl_scoreboard.sv
// reg_scoreboard: pending-write bit per architectural register.
// Ports: set_en/set_addr, two clear ports, rs1/rs2/rd lookups -> hits.
module reg_scoreboard
    import issue_hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [`REG_WIDTH-1:0] set_addr,
    input  logic                  clr_a_en,
    input  logic [`REG_WIDTH-1:0] clr_a_addr,
    input  logic                  clr_b_en,
    input  logic [`REG_WIDTH-1:0] clr_b_addr,
    input  logic [`REG_WIDTH-1:0] rs1_addr,
    input  logic [`REG_WIDTH-1:0] rs2_addr,
    input  logic [`REG_WIDTH-1:0] rd_addr,
    output logic                  rs1_hit,
    output logic                  rs2_hit,
    output logic                  rd_hit
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] eff_pending;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_a_en) clr_mask = clr_mask | reg_onehot(clr_a_addr);
        if (clr_b_en) clr_mask = clr_mask | reg_onehot(clr_b_addr);
        if (set_en)   set_mask = reg_onehot(set_addr);
        // Returning data is bypassed from WB, so a clear hides the bit now.
        eff_pending = pending_q & ~clr_mask;
        // Set after clear: a same-cycle set of the same register wins.
        pending_d   = eff_pending | set_mask;
    end

    assign rs1_hit = eff_pending[rs1_addr];
    assign rs2_hit = eff_pending[rs2_addr];
    assign rd_hit  = eff_pending[rd_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue-stage hazard control: RAW/WAW/structural stalls + divider FSM.
// In: ID fields, flush, load return. Out: id_stall, issue, div_* status.
// Optional ISSUE_HAZARD_PERF_EN adds saturating stall-class counters.
module issue_hazard_ctrl
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_rs1_en,
    input  logic                  id_rs2_en,
    input  logic [`REG_WIDTH-1:0] id_rs1_addr,
    input  logic [`REG_WIDTH-1:0] id_rs2_addr,
    input  logic                  id_rd_en,
    input  logic [`REG_WIDTH-1:0] id_rd_addr,
    input  logic                  id_is_load,
    input  logic                  id_is_div,
    input  logic                  flush,
    input  logic                  ld_ret_en,
    input  logic [`REG_WIDTH-1:0] ld_ret_addr,
    output logic                  id_stall,
    output logic                  issue,
    output logic                  div_start,
    output logic                  div_busy,
    output logic                  div_done,
    output logic [`REG_WIDTH-1:0] div_rd
`ifdef ISSUE_HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_raw_stalls,
    output logic [31:0]           perf_waw_stalls,
    output logic [31:0]           perf_div_stalls
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [`REG_WIDTH-1:0] div_rd_q, div_rd_d;

    logic rs1_hit, rs2_hit, rd_hit;
    logic raw_haz, waw_haz, struct_haz;
    logic sb_set;

    assign div_busy = (state_q != IDLE);
    assign div_done = (state_q == DONE);
    assign div_rd   = div_rd_q;

    assign raw_haz    = (id_rs1_en & rs1_hit) | (id_rs2_en & rs2_hit);
    assign waw_haz    = id_rd_en & rd_hit;
    // A finishing divider frees the unit in the same cycle.
    assign struct_haz = id_is_div & div_busy & ~div_done;

    assign id_stall  = id_valid & (raw_haz | waw_haz | struct_haz) & ~flush;
    assign issue     = id_valid & ~id_stall & ~flush;
    assign div_start = issue & id_is_div;

    assign sb_set = issue & id_rd_en & (id_is_load | id_is_div);

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (sb_set),
        .set_addr   (id_rd_addr),
        .clr_a_en   (ld_ret_en),
        .clr_a_addr (ld_ret_addr),
        .clr_b_en   (div_done),
        .clr_b_addr (div_rd_q),
        .rs1_addr   (id_rs1_addr),
        .rs2_addr   (id_rs2_addr),
        .rd_addr    (id_rd_addr),
        .rs1_hit    (rs1_hit),
        .rs2_hit    (rs2_hit),
        .rd_hit     (rd_hit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_rd_d = div_rd_q;
        unique case (state_q)
            IDLE: begin
                if (div_start) begin
                    state_d  = BUSY;
                    cnt_d    = CNT_LOAD;
                    div_rd_d = id_rd_addr;
                end
            end
            BUSY: begin
                // Leave on the 1->0 step so DONE lands DIV_CYCLES after start.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = DONE;
            end
            DONE: begin
                if (div_start) begin
                    state_d  = BUSY;
                    cnt_d    = CNT_LOAD;
                    div_rd_d = id_rd_addr;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_rd_q <= div_rd_d;
        end
    end

`ifdef ISSUE_HAZARD_PERF_EN
    logic [31:0] raw_cnt_q, raw_cnt_d;
    logic [31:0] waw_cnt_q, waw_cnt_d;
    logic [31:0] dvs_cnt_q, dvs_cnt_d;
    logic        raw_inc, waw_inc, dvs_inc;

    // One class per stall cycle: RAW, then WAW, then structural.
    assign raw_inc = id_stall & raw_haz;
    assign waw_inc = id_stall & ~raw_haz & waw_haz;
    assign dvs_inc = id_stall & ~raw_haz & ~waw_haz & struct_haz;

    always_comb begin
        raw_cnt_d = raw_cnt_q;
        waw_cnt_d = waw_cnt_q;
        dvs_cnt_d = dvs_cnt_q;
        if (raw_inc && raw_cnt_q != '1) raw_cnt_d = raw_cnt_q + 32'd1;
        if (waw_inc && waw_cnt_q != '1) waw_cnt_d = waw_cnt_q + 32'd1;
        if (dvs_inc && dvs_cnt_q != '1) dvs_cnt_d = dvs_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw_cnt_q <= '0;
            waw_cnt_q <= '0;
            dvs_cnt_q <= '0;
        end else begin
            raw_cnt_q <= raw_cnt_d;
            waw_cnt_q <= waw_cnt_d;
            dvs_cnt_q <= dvs_cnt_d;
        end
    end

    assign perf_raw_stalls = raw_cnt_q;
    assign perf_waw_stalls = waw_cnt_q;
    assign perf_div_stalls = dvs_cnt_q;
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Testbench for issue_hazard_ctrl: directed scenarios plus random
// stimulus against a timestamp-based behavioural model.
module tb_issue_hazard_ctrl;

    localparam int DIV_CYCLES = 33;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs1_en, id_rs2_en, id_rd_en;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic       id_is_load, id_is_div, flush;
    logic       ld_ret_en;
    logic [4:0] ld_ret_addr;
    logic       id_stall, issue, div_start, div_busy, div_done;
    logic [4:0] div_rd;
`ifdef ISSUE_HAZARD_PERF_EN
    logic [31:0] perf_raw_stalls, perf_waw_stalls, perf_div_stalls;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit        pend [32];
    int        cyc = 0;
    bit        m_act = 0;
    int        m_st = 0;
    bit  [4:0] m_rd = 0;
    bit        e_stall, e_issue, e_start, e_busy, e_done;

    always #5 clk = ~clk;

    issue_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1_en   (id_rs1_en),
        .id_rs2_en   (id_rs2_en),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rd_en    (id_rd_en),
        .id_rd_addr  (id_rd_addr),
        .id_is_load  (id_is_load),
        .id_is_div   (id_is_div),
        .flush       (flush),
        .ld_ret_en   (ld_ret_en),
        .ld_ret_addr (ld_ret_addr),
        .id_stall    (id_stall),
        .issue       (issue),
        .div_start   (div_start),
        .div_busy    (div_busy),
        .div_done    (div_done),
        .div_rd      (div_rd)
`ifdef ISSUE_HAZARD_PERF_EN
        ,
        .perf_raw_stalls (perf_raw_stalls),
        .perf_waw_stalls (perf_waw_stalls),
        .perf_div_stalls (perf_div_stalls)
`endif
    );

    function automatic bit eff(input bit [4:0] r);
        bit cl;
        cl = (ld_ret_en && ld_ret_addr == r) || (e_done && m_rd == r);
        return (r != 0) && pend[r] && !cl;
    endfunction

    task automatic model_eval();
        bit raw, waw, sh;
        e_busy  = m_act && (cyc > m_st);
        e_done  = m_act && (cyc == m_st + DIV_CYCLES);
        raw     = (id_rs1_en && eff(id_rs1_addr))
               || (id_rs2_en && eff(id_rs2_addr));
        waw     = id_rd_en && eff(id_rd_addr);
        sh      = id_is_div && e_busy && !e_done;
        e_stall = id_valid && (raw || waw || sh) && !flush;
        e_issue = id_valid && !e_stall && !flush;
        e_start = e_issue && id_is_div;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            foreach (pend[i]) pend[i] = 0;
            m_act = 0;
            m_rd  = 0;
        end else begin
            if (ld_ret_en) pend[ld_ret_addr] = 0;
            if (e_done) pend[m_rd] = 0;
            if (e_issue && id_rd_en && (id_is_load || id_is_div)
                && id_rd_addr != 0)
                pend[id_rd_addr] = 1;
            if (e_done && !e_start) m_act = 0;
            if (e_start) begin
                m_act = 1;
                m_st  = cyc;
                m_rd  = id_rd_addr;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        model_eval();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic v,
        input logic r1e, input logic [4:0] r1,
        input logic r2e, input logic [4:0] r2,
        input logic rde, input logic [4:0] rd,
        input logic ld,  input logic dv
    );
        id_valid    = v;
        id_rs1_en   = r1e;
        id_rs1_addr = r1;
        id_rs2_en   = r2e;
        id_rs2_addr = r2;
        id_rd_en    = rde;
        id_rd_addr  = rd;
        id_is_load  = ld;
        id_is_div   = dv;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush       = 0;
        ld_ret_en   = 0;
        ld_ret_addr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        tick();
        // Still in reset: hazard-free valid instruction issues.
        drive(1, 1, 3, 1, 4, 1, 6, 0, 0);
        #2;
        n_tests++;
        if (issue !== 1'b1 || id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_issue: got issue=%0b stall=%0b need 1/0",
                     issue, id_stall);
        end
        n_tests++;
        if (div_busy !== 1'b0 || div_done !== 1'b0 || div_start !== 1'b0
            || div_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_div: got busy=%0b done=%0b start=%0b rd=%0d need 0",
                     div_busy, div_done, div_start, div_rd);
        end
        idle();
        tick();
        rst_n = 1;
        #2;
        n_tests++;
        if (dut.u_sb.pending_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pending: got %h need 0", dut.u_sb.pending_q);
        end
    endtask

    task automatic test_load_raw();
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
        #2;
        n_tests++;
        if (issue !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_issue: got %0b need 1", issue);
        end
        tick();
        drive(1, 1, 5, 0, 0, 1, 6, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            n_tests++;
            if (id_stall !== 1'b1 || issue !== 1'b0) begin
                n_fail++;
                $display("FAIL ld_raw_stall: got stall=%0b issue=%0b need 1/0",
                         id_stall, issue);
            end
            tick();
        end
        ld_ret_en   = 1;
        ld_ret_addr = 5;
        #2;
        n_tests++;
        if (id_stall !== 1'b0 || issue !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_ret_release: got stall=%0b issue=%0b need 0/1",
                     id_stall, issue);
        end
        tick();
        idle();
        #2;
        n_tests++;
        if (dut.u_sb.pending_q !== 32'h0) begin
            n_fail++;
            $display("FAIL ld_ret_clear: got %h need 0", dut.u_sb.pending_q);
        end
    endtask

    task automatic test_load_x0();
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
        tick();
        drive(1, 1, 0, 1, 0, 1, 0, 0, 0);
        #2;
        n_tests++;
        if (issue !== 1'b1 || id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_consumer: got issue=%0b stall=%0b need 1/0",
                     issue, id_stall);
        end
        n_tests++;
        if (dut.u_sb.pending_q !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_pending: got %h need 0", dut.u_sb.pending_q);
        end
        tick();
    endtask

    task automatic test_div_back_to_back();
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 7, 0, 1);
        #2;
        n_tests++;
        if (div_start !== 1'b1 || issue !== 1'b1) begin
            n_fail++;
            $display("FAIL div_start: got start=%0b issue=%0b need 1/1",
                     div_start, issue);
        end
        tick();
        drive(1, 0, 0, 0, 0, 1, 9, 0, 1);
        for (int c = 1; c < DIV_CYCLES; c++) begin
            #2;
            n_tests++;
            if (id_stall !== 1'b1 || div_busy !== 1'b1 || div_done !== 1'b0) begin
                n_fail++;
                $display("FAIL div_struct c=%0d: got stall=%0b busy=%0b done=%0b need 1/1/0",
                         c, id_stall, div_busy, div_done);
            end
            tick();
        end
        #2;
        n_tests++;
        if (div_done !== 1'b1 || issue !== 1'b1 || div_start !== 1'b1
            || div_rd !== 5'd7) begin
            n_fail++;
            $display("FAIL div_b2b: got done=%0b issue=%0b start=%0b rd=%0d need 1/1/1/7",
                     div_done, issue, div_start, div_rd);
        end
        tick();
        for (int c = DIV_CYCLES + 1; c < 2 * DIV_CYCLES; c++) begin
            if (c < 50) drive(1, 1, 9, 0, 0, 1, 3, 0, 0);
            else        drive(1, 0, 0, 0, 0, 1, 9, 0, 0);
            #2;
            n_tests++;
            if (id_stall !== 1'b1 || div_busy !== 1'b1 || div_rd !== 5'd9) begin
                n_fail++;
                $display("FAIL div_dep c=%0d: got stall=%0b busy=%0b rd=%0d need 1/1/9",
                         c, id_stall, div_busy, div_rd);
            end
            tick();
        end
        #2;
        n_tests++;
        if (div_done !== 1'b1 || issue !== 1'b1) begin
            n_fail++;
            $display("FAIL div_waw_release: got done=%0b issue=%0b need 1/1",
                     div_done, issue);
        end
        tick();
        idle();
        #2;
        n_tests++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            n_fail++;
            $display("FAIL div_idle: got busy=%0b done=%0b need 0/0",
                     div_busy, div_done);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 3, 1, 0);
        flush = 1;
        #2;
        n_tests++;
        if (issue !== 1'b0 || id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_free: got issue=%0b stall=%0b need 0/0",
                     issue, id_stall);
        end
        tick();
        flush = 0;
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        #2;
        n_tests++;
        if (issue !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_noset: got issue=%0b need 1", issue);
        end
        tick();
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0);
        tick();
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
        flush = 1;
        #2;
        n_tests++;
        if (issue !== 1'b0 || id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_hazard: got issue=%0b stall=%0b need 0/0",
                     issue, id_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_div();
        bit seen;
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 7, 0, 1);
        tick();
        idle();
        for (int i = 0; i < 5; i++) tick();
        #2;
        n_tests++;
        if (div_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %0b need 1", div_busy);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        #2;
        n_tests++;
        if (div_busy !== 1'b0 || div_done !== 1'b0
            || dut.u_sb.pending_q !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%0b done=%0b pend=%h need 0",
                     div_busy, div_done, dut.u_sb.pending_q);
        end
        drive(1, 1, 7, 0, 0, 1, 8, 0, 0);
        #2;
        n_tests++;
        if (issue !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_consumer: got issue=%0b need 1", issue);
        end
        tick();
        idle();
        seen = 0;
        for (int i = 0; i < DIV_CYCLES + 5; i++) begin
            #2;
            if (div_done !== 1'b0) seen = 1;
            tick();
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_no_done: got div_done pulse need none");
        end
    endtask

    task automatic test_random();
        int kind;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            kind = $urandom_range(0, 9);
            drive($urandom_range(0, 9) < 8,
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                  kind < 3, kind == 3);
            flush       = ($urandom_range(0, 9) == 0);
            ld_ret_en   = ($urandom_range(0, 9) < 3);
            ld_ret_addr = 5'($urandom_range(0, 7));
            rst_n       = ($urandom_range(0, 199) != 0);
            #2;
            model_eval();
            n_tests++;
            if (id_stall !== e_stall || issue !== e_issue
                || div_start !== e_start) begin
                n_fail++;
                $display("FAIL rnd_issue i=%0d: got stall=%0b issue=%0b start=%0b need %0b/%0b/%0b",
                         i, id_stall, issue, div_start, e_stall, e_issue, e_start);
            end
            n_tests++;
            if (div_busy !== e_busy || div_done !== e_done
                || div_rd !== m_rd) begin
                n_fail++;
                $display("FAIL rnd_div i=%0d: got busy=%0b done=%0b rd=%0d need %0b/%0b/%0d",
                         i, div_busy, div_done, div_rd, e_busy, e_done, m_rd);
            end
            tick();
        end
        rst_n = 1;
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_raw();
        test_load_x0();
        test_div_back_to_back();
        test_flush();
        test_reset_mid_div();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_hazard_ctrl.md
# issue_hazard_ctrl

Issue-stage hazard controller and long-latency scoreboard for the in-order pipeline. It sits beside the ID-stage register-read and bypass path. It tracks destination registers of in-flight loads and divides whose data cannot yet be forwarded, and stalls ID on RAW/WAW hits. It also sequences the shared iterative divider through an IDLE/BUSY/DONE FSM so that only one divide is in flight.

## Interface
Parameters:
- DIV_CYCLES, 33: cycles the divider spends in BUSY (≥2).
- CNT_W, 6: divide counter width; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  core clock; one clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1_en / id_rs2_en  in  1  source read enables.
- id_rs1_addr / id_rs2_addr  in  `REG_WIDTH  source register numbers.
- id_rd_en  in  1  instruction writes rd.
- id_rd_addr  in  `REG_WIDTH  destination register.
- id_is_load  in  1  load instruction (load data is not forwardable until return).
- id_is_div  in  1  divide/remainder instruction.
- flush  in  1  EX redirect; squashes the ID instruction this cycle.
- ld_ret_en  in  1  load data returned and written this cycle.
- ld_ret_addr  in  `REG_WIDTH  returning load destination.
- id_stall  out  1  hold IF/ID.
- issue  out  1  ID instruction advances to EX this cycle.
- div_start  out  1  one-cycle pulse that launches the divider.
- div_busy  out  1  FSM not IDLE.
- div_done  out  1  one-cycle pulse, divide result valid for writeback.
- div_rd  out  `REG_WIDTH  destination of the in-flight divide.

## Operation
- pending[31:0] holds one bit per architectural register. Bit 0 is never set.
- Set: on issue with id_rd_en & (id_is_load | id_is_div) & id_rd_addr≠0, set pending[id_rd_addr].
- Clear: ld_ret_en clears pending[ld_ret_addr]. div_done clears pending[div_rd].
- Same-cycle set and clear of the same register: set wins.
- eff_pending = pending with this cycle's clears removed. The returning value reaches ID through the WB bypass, so it needs no extra stall cycle.
- RAW hazard: (id_rs1_en & eff_pending[rs1]) | (id_rs2_en & eff_pending[rs2]). Register 0 never hits.
- WAW hazard: id_rd_en & eff_pending[rd].
- Structural hazard: id_is_div & div_busy & ~div_done.
- id_stall = id_valid & (RAW | WAW | structural) & ~flush.
- issue = id_valid & ~id_stall & ~flush.
- Divider FSM:
  - IDLE → BUSY on issue & id_is_div. Asserts div_start, latches div_rd = id_rd_addr, loads counter = DIV_CYCLES-1.
  - BUSY: counter decrements each cycle; at 0 → DONE.
  - DONE: div_done = 1 for exactly one cycle. → BUSY if a divide issues this cycle (back-to-back), else → IDLE.
- flush never aborts an already-issued load or divide. Those instructions are older than the redirecting branch.

## Timing
- id_stall, issue and div_start are combinational from ID inputs and registered state. No flop on the issue path.
- Pending updates are visible from the next cycle.
- Divide latency: div_start in cycle T, div_done in cycle T+DIV_CYCLES. A dependent instruction issues in T+DIV_CYCLES via bypass.
- Reset (rst_n=0 at an edge): pending=0, FSM=IDLE, counter=0, div_rd=0. All outputs 0 except combinational id_stall/issue, which follow id_valid with pending clear.
- Reset mid-divide abandons the operation; no div_done is produced.

## Configuration
- ISSUE_HAZARD_PERF_EN defined: adds outputs perf_raw_stalls, perf_waw_stalls and perf_div_stalls, each 32 bits. Each counter increments on a stall cycle of its class and saturates at all-ones.
  - Priority when classes overlap: RAW > WAW > structural (one counter per cycle).
  - Counters reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared core package: div_state_e (IDLE, BUSY, DONE) and the one-hot register decode function. Widths stay on the existing `REG_WIDTH/`DATA_WIDTH macros.
- One sub-module, reg_scoreboard: the pending vector with set/clear ports and a two-read-port plus rd lookup. The FSM and stall logic stay in the top.

## Test plan
- Load x5 issues; next instruction reads x5 → id_stall=1 until ld_ret_en/addr=5. It issues in the ld_ret cycle.
- Load to x0, then a consumer of x0 → no stall; pending stays 0.
- DIV x7, DIV_CYCLES=33: div_start at T, div_done at T+33. A second DIV stalls until T+33 and then issues back-to-back (div_start=1, FSM DONE→BUSY).
- Consumer of x7 stalls during BUSY; WAW write to x7 by ADD also stalls; both release on div_done.
- flush together with a hazard-free id_valid → issue=0, id_stall=0, no pending set.
- Reset asserted during BUSY → div_busy=0 next cycle, no div_done, pending=0; a consumer of x7 issues immediately.
